// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-addressed data memory answering CPU load/store requests over a req/ack
// handshake with a fixed number of wait states. Misaligned and out-of-range
// accesses are acknowledged with err instead of aliasing into the array.
//
// Handshake: req is sampled only while idle (busy=0); the request is latched on
// that edge and all inputs are ignored until ack. ack is a one-cycle pulse,
// exactly one per accepted request; err qualifies it. rdata is valid while ack
// is high for a load and holds its value afterwards.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [31:0]       acc_addr;
  logic              acc_we;
  logic              enter_resp;
  logic              wr_en;

  // An address is rejected when it is not word aligned or lies beyond the array.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  // The load result must already be registered in the RESP cycle, so the read
  // is taken on the edge that enters RESP. With zero wait states that edge is
  // the accepting one, so the live inputs are used instead of the latched copy.
  always_comb begin
    acc_addr   = (state_q == S_IDLE) ? addr : addr_q;
    acc_we     = (state_q == S_IDLE) ? we   : we_q;
    enter_resp = ((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q <= 4'd1));
    rdata_d    = rdata_q;
    if (enter_resp && !acc_we && !addr_bad(acc_addr)) begin
      rdata_d = mem[acc_addr[ADDR_W+1:2]];
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, complete in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Completion outputs; a reset arriving in RESP suppresses the response.
  always_comb begin
    busy      = (state_q != S_IDLE);
    ack       = (state_q == S_RESP) && !rst;
    err       = ack && addr_bad(addr_q);
    wr_en     = ack && we_q && !addr_bad(addr_q);
    rdata     = rdata_q;
    state_dbg = state_q;
  end

  // Control and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-enabled store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be_q[i]) begin
          mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Two instances: u_dut0 with two wait states, u_dut1 with none. Requests are
// issued by driver tasks; a reference model predicts each response and pushes
// it onto a scoreboard queue, and a monitor forked alongside the stimulus pops
// and compares whenever an instance pulses ack.
module tb_data_mem_responder;

  localparam int AW = 10;
  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct {
    int          d;
    int          exp_cyc;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req       [2];
  logic        we        [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [3:0]  be        [2];
  logic        ack       [2];
  logic [31:0] rdata     [2];
  logic        err       [2];
  logic        busy      [2];
  logic [1:0]  state_dbg [2];

  int          cyc;
  int          checks;
  int          errors;
  exp_t        exp_q [$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];
  bit          last_known [2];

  data_mem_responder #(.ADDR_W(AW), .DATA_W(32), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ack(ack[0]), .rdata(rdata[0]),
    .err(err[0]), .busy(busy[0]), .state_dbg(state_dbg[0])
  );

  data_mem_responder #(.ADDR_W(AW), .DATA_W(32), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ack(ack[1]), .rdata(rdata[1]),
    .err(err[1]), .busy(busy[1]), .state_dbg(state_dbg[1])
  );

  // Clock and cycle counter; cycle k runs from edge k to edge k+1.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word memory keyed by instance and word index; tracks
  // the rdata each instance should be holding.
  function automatic void push_expect(input int d, input bit w, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] b, input int c);
    exp_t        e;
    int          key;
    bit          bad;
    logic [31:0] word;
    bad = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    key = d * 65536 + int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    e.d       = d;
    e.exp_cyc = c + ((d == 0) ? W0 : W1) + 1;
    e.err     = bad;
    e.chk     = last_known[d];
    e.data    = last_rd[d];
    if (!bad) begin
      if (w) begin
        if (b == 4'hf) begin
          ref_mem[key] = wd;
        end else if (ref_mem.exists(key)) begin
          word = ref_mem[key];
          for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
          ref_mem[key] = word;
        end
      end else if (ref_mem.exists(key)) begin
        e.chk         = 1'b1;
        e.data        = ref_mem[key];
        last_rd[d]    = e.data;
        last_known[d] = 1'b1;
      end else begin
        e.chk         = 1'b0;
        last_known[d] = 1'b0;
      end
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: runs every falling edge, matches acks against the scoreboard.
  task automatic monitor_step();
    exp_t e;
    int   idx;
    for (int d = 0; d < 2; d++) begin
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].d == d) begin
          idx = i;
          break;
        end
      end
      if (ack[d]) begin
        check($sformatf("ack_implies_busy[%0d]", d), 32'(busy[d]), 32'd1);
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack[%0d]: got ack=1 expected no ack (cycle %0d)", d, cyc);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          check($sformatf("ack_cycle[%0d]", d), 32'(cyc), 32'(e.exp_cyc));
          check($sformatf("err[%0d]", d), 32'(err[d]), 32'(e.err));
          if (e.chk) check($sformatf("rdata[%0d]", d), rdata[d], e.data);
        end
      end else if (idx >= 0 && cyc > exp_q[idx].exp_cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_ack[%0d]: got no ack expected ack in cycle %0d (now %0d)",
                 d, exp_q[idx].exp_cyc, cyc);
        exp_q.delete(idx);
      end
    end
  endtask

  // Driver: waits for idle, presents one request, then scrambles the inputs
  // while the instance is busy (they must be ignored). Returns in the ack cycle.
  // With abort set nothing is predicted and it returns right after acceptance.
  task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input bit abort);
    int c;
    int n;
    int wc;
    wc = (d == 0) ? W0 : W1;
    @(negedge clk);
    n = 0;
    while (busy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy[d]) begin
      check($sformatf("idle_timeout[%0d]", d), 32'(busy[d]), 32'd0);
      return;
    end
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    c = cyc;
    if (!abort) push_expect(d, w, a, wd, b, c);
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    if (abort) return;
    for (int k = 1; k <= wc + 1; k++) begin
      @(negedge clk);
      req[d]   = (k == wc + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      we[d]    = 1'($urandom_range(0, 1));
      addr[d]  = $urandom;
      wdata[d] = $urandom;
      be[d]    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_rd[d]    = 32'd0;
      last_known[d] = 1'b1;
    end
  endtask

  initial begin
    int          c0;
    int          n;
    bit          w;
    logic [31:0] a;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; be[d] = 4'd0;
    end
    model_reset();
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ack[%0d]", d), 32'(ack[d]), 32'd0);
      check($sformatf("reset_err[%0d]", d), 32'(err[d]), 32'd0);
      check($sformatf("reset_busy[%0d]", d), 32'(busy[d]), 32'd0);
      check($sformatf("reset_rdata[%0d]", d), rdata[d], 32'd0);
      check($sformatf("reset_state[%0d]", d), 32'(state_dbg[d]), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Full store then load; byte-lane merge.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    issue(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    #1 check("merged_word", rdata[0], 32'hDEADAAEF);
    issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hf, 1'b0);

    // Rejected accesses leave the array and rdata alone.
    issue(0, 1'b1, 32'h0, 32'h11223344, 4'hf, 1'b0);
    issue(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0);
    #1 check("rdata_kept_on_err", rdata[0], 32'hDEADAAEF);
    issue(0, 1'b1, 32'h0000_1000, 32'hBADBAD00, 4'hf, 1'b0);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #1 check("word0_unchanged", rdata[0], 32'h11223344);

    // req held high for ten cycles: accepts in cycles 0, 4 and 8.
    @(negedge clk);
    c0 = cyc;
    push_expect(0, 1'b0, 32'h10, 32'h0, 4'h0, c0);
    push_expect(0, 1'b0, 32'h10, 32'h0, 4'h0, c0 + 4);
    push_expect(0, 1'b0, 32'h10, 32'h0, 4'h0, c0 + 8);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("busy_held_req_c%0d", k), 32'(busy[0]), (k % 4 == 0) ? 32'd0 : 32'd1);
    end
    req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during WAIT discards the store.
    issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hf, 1'b0);
    issue(0, 1'b1, 32'h20, 32'h12345678, 4'hf, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("wait_rst_busy", 32'(busy[0]), 32'd0);
    check("wait_rst_state", 32'(state_dbg[0]), 32'd0);
    check("wait_rst_ack", 32'(ack[0]), 32'd0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

    // Reset coinciding with RESP: no ack, no write.
    issue(0, 1'b1, 32'h20, 32'h55555555, 4'hf, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("resp_rst_ack", 32'(ack[0]), 32'd0);
    check("resp_rst_err", 32'(err[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("resp_rst_busy", 32'(busy[0]), 32'd0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

    // Zero wait states: back-to-back alternating store/load stream.
    for (int k = 0; k < 8; k++) begin
      a = 32'(k / 2) << 2;
      issue(1, (k % 2 == 0), a, $urandom, 4'hf, 1'b0);
    end

    // Randomized traffic on both instances over a preloaded window.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) issue(d, 1'b1, 32'h40 + 32'(i * 4), $urandom, 4'hf, 1'b0);
      for (int i = 0; i < 40; i++) begin
        a = 32'h40 + (32'($urandom_range(0, 15)) << 2);
        n = $urandom_range(0, 9);
        if (n == 0) a = a | 32'($urandom_range(1, 3));
        if (n == 1) a = a | (32'd1 << $urandom_range(12, 31));
        w = 1'($urandom_range(0, 1));
        issue(d, w, a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
